// File: rtl/deal_pkg.sv
// deal_pkg: shared definitions for the baccarat deal controller.
//   deal_state_t  - sequencing states of the controller FSM
//   NATURAL_MIN   - two-card score at or above which the hand ends (natural)
//   STAND_MIN     - score at or above which a hand stands on two cards
//   FACE_MIN      - raw card code at or above which the card counts as zero
//   card_value()  - raw card code (0..13) to baccarat point value
package deal_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_CHK,
    S_P3,
    S_BCHK,
    S_D3,
    S_DONE
  } deal_state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] STAND_MIN   = 4'd6;
  localparam logic [3:0] FACE_MIN    = 4'd10;

  // Tens and face cards (codes 10..13) are worth zero points.
  function automatic logic [3:0] card_value(input logic [3:0] raw);
    return (raw >= FACE_MIN) ? 4'd0 : raw;
  endfunction

endpackage

// File: rtl/deal_controller_banker_rule.sv
// banker_rule: combinational banker third-card decision.
//   dscore [3:0] in  - banker two-card score
//   pcard3 [3:0] in  - raw player third card code (0..13)
//   draw         out - 1 when the banker takes a third card
// Banker scores of 7 and above (and out-of-range values) always stand.
module banker_rule
  import deal_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_controller.sv
// deal_controller: sequencing FSM for one baccarat hand.
//   slow_clock      in  - clock; the datapath loads cards on the same edge
//   resetb          in  - synchronous active-high reset
//   pscore_out[3:0] in  - player score from the datapath
//   dscore_out[3:0] in  - dealer score from the datapath
//   pcard3_out[3:0] in  - raw player third card (0 = none)
//   deal_hold       in  - freezes dealing (only when DEAL_HOLD_EN is defined)
//   load_pcard1..3  out - player card load strobes (one-hot, one cycle)
//   load_dcard1..3  out - dealer card load strobes (one-hot, one cycle)
//   player_win      out - player won or tied, valid in S_DONE only
//   dealer_win      out - dealer won or tied, valid in S_DONE only
//   state_dbg       out - current FSM state for observation
// Build option: define DEAL_HOLD_EN to add the deal_hold input.
module deal_controller
  import deal_pkg::*;
(
  input  logic        slow_clock,
  input  logic        resetb,
  input  logic [3:0]  pscore_out,
  input  logic [3:0]  dscore_out,
  input  logic [3:0]  pcard3_out,
`ifdef DEAL_HOLD_EN
  input  logic        deal_hold,
`endif
  output logic        load_pcard1,
  output logic        load_pcard2,
  output logic        load_pcard3,
  output logic        load_dcard1,
  output logic        load_dcard2,
  output logic        load_dcard3,
  output logic        player_win,
  output logic        dealer_win,
  output deal_state_t state_dbg
);

  deal_state_t state;
  deal_state_t next_state;
  logic        hold;
  logic        banker_draw;

`ifdef DEAL_HOLD_EN
  assign hold = deal_hold;
`else
  assign hold = 1'b0;
`endif

  banker_rule u_banker_rule (
    .dscore (dscore_out),
    .pcard3 (pcard3_out),
    .draw   (banker_draw)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_P1:   next_state = S_D1;
      S_D1:   next_state = S_P2;
      S_P2:   next_state = S_D2;
      S_D2:   next_state = S_CHK;
      S_CHK: begin
        if ((pscore_out >= NATURAL_MIN) || (dscore_out >= NATURAL_MIN))
          next_state = S_DONE;
        else if (pscore_out < STAND_MIN)
          next_state = S_P3;
        else if (dscore_out < STAND_MIN)
          next_state = S_D3;
        else
          next_state = S_DONE;
      end
      S_P3:   next_state = S_BCHK;
      S_BCHK: next_state = banker_draw ? S_D3 : S_DONE;
      S_D3:   next_state = S_DONE;
      S_DONE: next_state = S_DONE;
      default: next_state = S_P1;
    endcase
  end

  // Reset wins over hold; a held state simply repeats, so its strobe
  // reappears once the hold drops.
  always_ff @(posedge slow_clock) begin
    if (resetb)
      state <= S_P1;
    else if (!hold)
      state <= next_state;
  end

  assign load_pcard1 = (state == S_P1) && !hold;
  assign load_dcard1 = (state == S_D1) && !hold;
  assign load_pcard2 = (state == S_P2) && !hold;
  assign load_dcard2 = (state == S_D2) && !hold;
  assign load_pcard3 = (state == S_P3) && !hold;
  assign load_dcard3 = (state == S_D3) && !hold;

  // No loads happen in S_DONE, so the scores (and these flags) are stable.
  assign player_win = (state == S_DONE) && (pscore_out >= dscore_out);
  assign dealer_win = (state == S_DONE) && (dscore_out >= pscore_out);

  assign state_dbg = state;

endmodule
